// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped, write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL     = 2'd1,
    WRITE_THRU = 2'd2
  } state_e;

  function automatic int tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int block_words(input int offset_w);
    return 1 << offset_w;
  endfunction

endpackage

// File: rtl/dcache_storage.sv
// Tag/valid/data arrays: combinational read of one line/word, word-granular data write, line fill.
// Valid bits clear synchronously on rst; tags and data are not reset.
module dcache_storage
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [INDEX_W-1:0]                        index_i,
  input  logic [OFFSET_W-1:0]                       rd_offset_i,
  output logic [tag_w(ADDR_W, INDEX_W, OFFSET_W)-1:0] tag_o,
  output logic                                      valid_o,
  output logic [DATA_W-1:0]                         rdata_o,
  input  logic                                      data_we_i,
  input  logic [OFFSET_W-1:0]                       wr_offset_i,
  input  logic [DATA_W-1:0]                         wdata_i,
  input  logic                                      fill_we_i,
  input  logic [tag_w(ADDR_W, INDEX_W, OFFSET_W)-1:0] fill_tag_i
);

  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = LINES * block_words(OFFSET_W);

  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [LINES-1:0]  valid_q;
  logic [DATA_W-1:0] data_q  [WORDS];

  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign rdata_o = data_q[{index_i, rd_offset_i}];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_we_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we_i) begin
      tag_q[index_i] <= fill_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we_i) begin
      data_q[{index_i, wr_offset_i}] <= wdata_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate data cache: hits return in the same cycle,
// misses refill a block; stall is combinational and holds the core until the access completes.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mm_req,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata,
  input  logic              mm_rvalid,
  input  logic              mm_ack
);

  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, OFFSET_W);

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic                mm_req_q, mm_we_q;

  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic [TAG_W-1:0]    req_tag;
  logic [TAG_W-1:0]    line_tag;
  logic                line_valid;
  logic [DATA_W-1:0]   line_rdata;
  logic                hit;

  logic                data_we;
  logic                fill_we;
  logic [OFFSET_W-1:0] wr_offset;
  logic [DATA_W-1:0]   wr_data;

  assign index   = addr[OFFSET_W +: INDEX_W];
  assign offset  = addr[OFFSET_W-1:0];
  assign req_tag = addr[ADDR_W-1 -: TAG_W];
  assign hit     = line_valid && (line_tag == req_tag);

  dcache_storage #(
    .ADDR_W   (ADDR_W),
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W),
    .DATA_W   (DATA_W)
  ) u_storage (
    .clk         (clk),
    .rst         (rst),
    .index_i     (index),
    .rd_offset_i (offset),
    .tag_o       (line_tag),
    .valid_o     (line_valid),
    .rdata_o     (line_rdata),
    .data_we_i   (data_we),
    .wr_offset_i (wr_offset),
    .wdata_i     (wr_data),
    .fill_we_i   (fill_we),
    .fill_tag_i  (req_tag)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    stall     = 1'b0;
    data_we   = 1'b0;
    fill_we   = 1'b0;
    wr_offset = offset;
    wr_data   = wdata;
    case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read; hits update the cached word on entry.
        if (mem_write) begin
          stall   = 1'b1;
          data_we = hit;
          state_d = WRITE_THRU;
        end else if (mem_read && !hit) begin
          stall   = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (mm_rvalid) begin
          data_we   = 1'b1;
          wr_offset = beat_q;
          wr_data   = mm_rdata;
          beat_d    = beat_q + 1'b1;
          if (&beat_q) begin
            fill_we = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WRITE_THRU: begin
        stall = !mm_ack;
        if (mm_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts any transaction and must not leave a partially filled line valid.
    if (rst) begin
      stall   = 1'b0;
      data_we = 1'b0;
      fill_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      mm_req_q <= 1'b0;
      mm_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      mm_req_q <= (state_d != IDLE);
      mm_we_q  <= (state_d == WRITE_THRU);
    end
  end

  assign mm_req   = mm_req_q && !rst;
  assign mm_we    = mm_we_q && !rst;
  assign mm_addr  = mm_we_q ? addr : {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign mm_wdata = wdata;
  assign rdata    = rst ? '0 : line_rdata;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed plus random accesses against a memory-image / tag-table reference model.
module tb_dcache_controller;

  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [9:0]  addr;
  logic [31:0] wdata, rdata;
  logic        stall, mm_req, mm_we;
  logic [9:0]  mm_addr;
  logic [31:0] mm_wdata, mm_rdata;
  logic        mm_rvalid, mm_ack;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem   [1024];
  bit          vld_m [32];
  logic [2:0]  tag_m [32];

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mm_req    (mm_req),
    .mm_we     (mm_we),
    .mm_addr   (mm_addr),
    .mm_wdata  (mm_wdata),
    .mm_rdata  (mm_rdata),
    .mm_rvalid (mm_rvalid),
    .mm_ack    (mm_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [9:0] a);
    return vld_m[a[6:2]] && (tag_m[a[6:2]] == a[9:7]);
  endfunction

  // Drive one memory-side cycle: refill beats start lat cycles after mm_req rises,
  // write ack arrives on the lat-th cycle of the write request.
  task automatic drive_mem(input int req_cnt, input int lat);
    int b;
    mm_rvalid = 1'b0;
    mm_ack    = 1'b0;
    mm_rdata  = '0;
    if (mm_req && !mm_we) begin
      b = req_cnt - lat;
      if (b >= 0 && b < BW) begin
        mm_rvalid = 1'b1;
        mm_rdata  = mem[{mm_addr[9:2], 2'(b)}];
      end
    end
    if (mm_req && mm_we && req_cnt == lat - 1) mm_ack = 1'b1;
  endtask

  task automatic access(input logic [9:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input int lat);
    int  req_cnt = 0;
    int  stalls = 0;
    int  exp_stalls;
    bit  done = 0;
    bit  exp_hit;
    bit  saw_refill = 0;
    bit  saw_bad = 0;
    exp_hit    = model_hit(a);
    exp_stalls = wr ? lat : (exp_hit ? 0 : lat + BW + 1);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) @(negedge clk);
      drive_mem(req_cnt, lat);
      #1;
      if (c == 0) chk("idle_mm_req", 32'(mm_req), 32'd0);
      if (mm_req && !mm_we) begin
        saw_refill = 1;
        if (mm_addr !== {a[9:2], 2'b00}) saw_bad = 1;
      end
      if (mm_req && mm_we && (mm_addr !== a || mm_wdata !== wd)) saw_bad = 1;
      if (!stall) done = 1;
      else stalls++;
      if (done && rd && !wr) chk($sformatf("rdata@%0h", a), rdata, mem[a]);
      if (mm_req) req_cnt++;
    end
    chk($sformatf("done@%0h", a), 32'(done), 32'd1);
    chk($sformatf("stalls@%0h", a), 32'(stalls), 32'(exp_stalls));
    chk($sformatf("refill_issued@%0h", a), 32'(saw_refill), 32'(rd && !wr && !exp_hit));
    chk($sformatf("mm_addr_wdata@%0h", a), 32'(saw_bad), 32'd0);
    if (wr) mem[a] = wd;
    else if (rd && !exp_hit) begin
      vld_m[a[6:2]] = 1'b1;
      tag_m[a[6:2]] = a[9:7];
    end
    @(posedge clk);
    #1;
    mem_read = 0; mem_write = 0; mm_rvalid = 0; mm_ack = 0;
  endtask

  // Read miss that is reset while refill beat `abort_beat` is on the bus.
  task automatic abort_read(input logic [9:0] a, input int lat, input int abort_beat);
    int req_cnt = 0;
    bit fired = 0;
    @(negedge clk);
    mem_read = 1; mem_write = 0; addr = a;
    for (int c = 0; c < 200 && !fired; c++) begin
      if (c > 0) @(negedge clk);
      drive_mem(req_cnt, lat);
      if (mm_req && req_cnt == lat + abort_beat) begin
        rst = 1'b1;
        fired = 1;
      end
      #1;
      if (mm_req) req_cnt++;
    end
    chk("abort_reached", 32'(fired), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mm_req", 32'(mm_req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_read = 0; mm_rvalid = 0;
    for (int i = 0; i < 32; i++) vld_m[i] = 1'b0;
    @(negedge clk);
    chk("post_rst_mm_req", 32'(mm_req), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    logic [9:0] ra;
    int         op;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 32; i++) begin vld_m[i] = 0; tag_m[i] = '0; end
    mem[10'h040] = 32'h11; mem[10'h041] = 32'h22;
    mem[10'h042] = 32'h33; mem[10'h043] = 32'h44;
    rst = 1; mem_read = 0; mem_write = 0; addr = '0; wdata = '0;
    mm_rdata = '0; mm_rvalid = 0; mm_ack = 0;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1; mem_write = 1; addr = 10'h040;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mm_req", 32'(mm_req), 32'd0);
    chk("reset_mm_we", 32'(mm_we), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 0; mem_read = 0; mem_write = 0;

    access(10'h040, 1, 0, '0, 3);
    access(10'h041, 1, 0, '0, 3);
    access(10'h140, 1, 0, '0, 2);
    access(10'h040, 1, 0, '0, 1);
    access(10'h042, 0, 1, 32'hDEADBEEF, 2);
    access(10'h042, 1, 0, '0, 2);
    access(10'h300, 0, 1, 32'h0BADF00D, 1);
    access(10'h300, 1, 0, '0, 2);
    abort_read(10'h080, 2, 2);
    access(10'h080, 1, 0, '0, 2);
    access(10'h010, 1, 1, 32'hCAFEF00D, 2);
    access(10'h010, 1, 0, '0, 1);

    for (int n = 0; n < 60; n++) begin
      ra = {3'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 9);
      if (op < 6)      access(ra, 1, 0, '0, $urandom_range(0, 3));
      else if (op < 9) access(ra, 0, 1, $urandom, $urandom_range(1, 3));
      else             access(ra, 1, 1, $urandom, $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
